fir_seq_ctrl: RTL and testbench
===============================

Name: fir_seq_ctrl

Overview:
Sequencer that fronts a shared sample queue and drives the `sequencing` window of the FIR band filters.
- Tracks the circular write pointer for incoming audio samples and counts fill level.
- On each new sample, once TAPS samples are resident, replays the newest TAPS samples oldest-first while holding `sequencing` high for exactly TAPS cycles.
- Pulses `fir_done` when the filter outputs are final.
- Sits between the I2S/sample-capture logic, the sample RAM and all FIR band instances, which share one `sequencing`.

Parameters:
- DEPTH, 1024, queue entries; power of two; must be >= TAPS+2.
- TAPS, 1021, filter length = `sequencing` window length in cycles; >= 2.
- AW, $clog2(DEPTH), address width.

Ports:
- clk        in   1   system clock
- rst_n      in   1   asynchronous active-low reset
- wrt_smpl   in   1   1-cycle strobe: new L/R sample present on RAM write data this cycle
- we         out  1   RAM write enable; combinational copy of wrt_smpl
- waddr      out  AW  RAM write address (registered pointer)
- raddr      out  AW  RAM read address during replay
- sequencing out  1   FIR convolution window, registered
- fir_done   out  1   1-cycle pulse; FIR lft_out/rght_out valid from this cycle
- full       out  1   TAPS samples resident (sticky until reset)
- ovr        out  1   sticky overrun flag

Behaviour:
- Reset: waddr=0, raddr=0, sequencing=0, fir_done=0, full=0, ovr=0, fill=0, pend=0, state=IDLE. Any reset mid-replay aborts immediately; no fir_done is issued.

Write side (independent of state):
- we = wrt_smpl.
- On wrt_smpl: waddr <= waddr+1, mod DEPTH (natural AW-bit wrap).
- fill saturates at TAPS; full = (fill == TAPS).

Launch condition (trigger): wrt_smpl && (fill+1 >= TAPS). The write that completes the first TAPS samples therefore triggers.

State machine (enum IDLE, SEQ, DONE):
- IDLE:
  - On trigger: base = waddr - (TAPS-1), mod DEPTH, where waddr is this cycle's write address (newest sample).
  - raddr <= base; cnt <= 0; go to SEQ.
  - Else, if pend: launch the same way using newest = waddr-1; clear pend.
- SEQ:
  - sequencing = 1 every cycle in this state.
  - raddr <= raddr+1 (wraps); cnt <= cnt+1.
  - When cnt == TAPS-1, go to DONE, so sequencing is high exactly TAPS cycles.
  - Read data latency is 1 cycle from raddr and matches FIR ROM addr latency; no extra alignment.
- DONE:
  - sequencing = 0 and fir_done = 1 for one cycle, then go to IDLE.
  - A trigger in this cycle sets pend.

Triggers while busy:
- A trigger in SEQ or DONE still writes (waddr advances) and sets pend.
- A trigger while pend is already 1 sets ovr. The sequence is dropped, but the sample is still stored.
- IDLE with pend and a new trigger in the same cycle: launch on the new trigger, clear pend, no ovr.

Other rules:
- With no trigger, outputs hold and raddr holds its last value.
- Replay ordering: first raddr = oldest of the TAPS window, last raddr = newest sample.
- Latency: trigger at cycle T → sequencing high T+1..T+TAPS → fir_done at T+TAPS+1.
- Back-to-back via pend: next sequencing rises at fir_done+2.

Decomposition:
- Package fir_seq_pkg:
  - seq_state_t enum {IDLE, SEQ, DONE}.
  - Localparams DEF_DEPTH=1024 and DEF_TAPS=1021.
  - Function wrap_sub(ptr, off) for modular address math.
- One sub-module, wrap_ptr: AW-bit register with load/incr/clr and async reset, instantiated for waddr and raddr.
- The state machine and counters stay in fir_seq_ctrl.

Test Plan (DEPTH=16, TAPS=8 unless noted):
- Fill: 7 wrt_smpl strobes → no sequencing, full=0, waddr=7. 8th strobe (waddr=7) → next cycle sequencing=1 for exactly 8 cycles, raddr 0..7, fir_done pulse one cycle after the fall, full=1.
- Wrap: strobe at waddr=2 with full=1 → raddr sequence 11,12,13,14,15,0,1,2; waddr→3.
- Busy trigger: strobe in 3rd SEQ cycle → sample written, pend=1. After fir_done, relaunch with base=newest-7, ovr=0.
- Overrun: two strobes during one SEQ → ovr=1 and stays 1; only one extra sequence runs.
- Reset mid-SEQ (cycle 4): all outputs 0 at once, no fir_done. Next 8 strobes are needed before the next launch.
- Default params: 1021 strobes → sequencing high exactly 1021 cycles; fir_done at trigger+1022; raddr ends at 1020.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared state encoding, default sizes and modular pointer math for the FIR sequencer
package fir_seq_pkg;
  typedef enum logic [1:0] {IDLE, SEQ, DONE} seq_state_t;
  localparam int DEF_DEPTH = 1024;
  localparam int DEF_TAPS = 1021;
  // depth is a power of two, so masking gives the modulo even for negative differences
  function automatic int wrap_sub(int ptr, int off, int depth);
    return (ptr - off) & (depth - 1);
  endfunction
endpackage

// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: sample-queue / FIR sequencing bus
//   master (capture side): drives wrt_smpl, observes everything else
//   slave  (fir_seq_ctrl): we, waddr, raddr, sequencing, fir_done, full, ovr
interface fir_seq_ctrl_if #(parameter int AW = 10);
  logic wrt_smpl, we, sequencing, fir_done, full, ovr;
  logic [AW-1:0] waddr, raddr;
  modport master (output wrt_smpl, input we, waddr, raddr, sequencing, fir_done, full, ovr);
  modport slave (input wrt_smpl, output we, waddr, raddr, sequencing, fir_done, full, ovr);
endinterface

// File: rtl/wrap_ptr.sv
// wrap_ptr: AW-bit wrapping pointer register with clear/load/increment
//   clk, rst_n: clock, async active-low reset
//   clr_i > load_i > incr_i priority; d_i load value; q_o current pointer
module wrap_ptr #(parameter int AW = 10) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          incr_i,
  input  logic [AW-1:0] d_i,
  output logic [AW-1:0] q_o
);
  logic [AW-1:0] q_q, q_d;
  always_comb q_d = clr_i ? '0 : load_i ? d_i : incr_i ? q_q + 1'b1 : q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sample-queue write pointer, fill tracking and TAPS-cycle FIR replay sequencer
//   clk, rst_n: clock, async active-low reset
//   bus (slave): wrt_smpl in; we, waddr, raddr, sequencing, fir_done, full, ovr out
module fir_seq_ctrl
  import fir_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAPS  = DEF_TAPS,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst_n,
  fir_seq_ctrl_if.slave bus
);
  localparam int FW = $clog2(TAPS + 1);
  localparam int CW = $clog2(TAPS);
  seq_state_t state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, ovr_q, ovr_d, seq_q, done_q;
  logic trig, r_load, r_incr;
  logic [AW-1:0] waddr, raddr, base;
  assign trig = bus.wrt_smpl && (fill_q >= FW'(TAPS - 1));
  assign fill_d = (bus.wrt_smpl && fill_q != FW'(TAPS)) ? fill_q + 1'b1 : fill_q;
  // a fresh trigger's newest sample is this cycle's waddr; a pended one's is waddr-1
  assign base = AW'(wrap_sub(int'(waddr), trig ? TAPS - 1 : TAPS, DEPTH));
  wrap_ptr #(.AW(AW)) u_wptr (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .load_i(1'b0),
    .incr_i(bus.wrt_smpl), .d_i('0), .q_o(waddr)
  );
  wrap_ptr #(.AW(AW)) u_rptr (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .load_i(r_load),
    .incr_i(r_incr), .d_i(base), .q_o(raddr)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    ovr_d = ovr_q;
    r_load = 1'b0;
    r_incr = 1'b0;
    case (state_q)
      IDLE: if (trig || pend_q) begin
        r_load = 1'b1;
        cnt_d = '0;
        pend_d = 1'b0;
        state_d = SEQ;
      end
      SEQ: begin
        // raddr parks on the newest sample once the window ends
        r_incr = cnt_q != CW'(TAPS - 1);
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(TAPS - 1) ? DONE : SEQ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (trig && state_q != IDLE) begin
      pend_d = 1'b1;
      ovr_d = ovr_q | pend_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      ovr_q <= 1'b0;
      seq_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
      seq_q <= state_d == SEQ;
      done_q <= state_d == DONE;
    end
  assign bus.we = bus.wrt_smpl;
  assign bus.waddr = waddr;
  assign bus.raddr = raddr;
  assign bus.sequencing = seq_q;
  assign bus.fir_done = done_q;
  assign bus.full = fill_q == FW'(TAPS);
  assign bus.ovr = ovr_q;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: scoreboard bench for fir_seq_ctrl (small 16/8 instance plus a default-size instance)
module tb_fir_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int mw = 0;
  int mfill = 0;
  bit mpend = 1'b0;
  bit movr = 1'b0;
  int q[$];

  fir_seq_ctrl_if #(.AW(4)) sif ();
  fir_seq_ctrl_if #(.AW(10)) bif ();

  fir_seq_ctrl #(.DEPTH(16), .TAPS(8)) u_small (.clk(clk), .rst_n(rst_n), .bus(sif));
  fir_seq_ctrl u_big (.clk(clk), .rst_n(rst_n), .bus(bif));

  always #5 clk = ~clk;

  function automatic void push_win(int newest);
    for (int i = 0; i < 8; i++) q.push_back((newest - (7 - i)) & 15);
  endfunction

  task automatic strobe_idle();
    if (mfill + 1 >= 8) push_win(mw);
    sif.wrt_smpl = 1'b1;
    #1;
    checks++;
    if (sif.we !== 1'b1) begin errors++; $display("FAIL we: got %0b expected 1", sif.we); end
    @(negedge clk);
    sif.wrt_smpl = 1'b0;
    mw = (mw + 1) & 15;
    if (mfill < 8) mfill++;
    checks++;
    if (int'(sif.waddr) !== mw) begin errors++; $display("FAIL waddr: got %0d expected %0d", sif.waddr, mw); end
  endtask

  task automatic run_window(input int s1, input int s2, input int exp_w);
    int w, n, e;
    w = 0;
    n = 0;
    while (sif.sequencing !== 1'b1 && w < 6) begin @(negedge clk); w++; end
    checks++;
    if (w !== exp_w) begin errors++; $display("FAIL launch_delay: got %0d expected %0d", w, exp_w); end
    while (sif.sequencing === 1'b1 && n < 20) begin
      e = q.size() == 0 ? -1 : q.pop_front();
      checks++;
      if (int'(sif.raddr) !== e) begin errors++; $display("FAIL raddr[%0d]: got %0d expected %0d", n, sif.raddr, e); end
      if (n == s1 || n == s2) begin
        sif.wrt_smpl = 1'b1;
        if (mpend) movr = 1'b1;
        mpend = 1'b1;
        mw = (mw + 1) & 15;
      end
      @(negedge clk);
      sif.wrt_smpl = 1'b0;
      n++;
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL seq_len: got %0d expected 8", n); end
    checks++;
    if (sif.fir_done !== 1'b1) begin errors++; $display("FAIL fir_done_pulse: got %0b expected 1", sif.fir_done); end
    @(negedge clk);
    checks++;
    if (sif.fir_done !== 1'b0) begin errors++; $display("FAIL fir_done_width: got %0b expected 0", sif.fir_done); end
    checks++;
    if (sif.ovr !== movr) begin errors++; $display("FAIL ovr: got %0b expected %0b", sif.ovr, movr); end
    checks++;
    if (int'(sif.waddr) !== mw) begin errors++; $display("FAIL waddr_win: got %0d expected %0d", sif.waddr, mw); end
    if (mpend) begin push_win((mw - 1) & 15); mpend = 1'b0; end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({sif.waddr, sif.raddr, sif.sequencing, sif.fir_done, sif.full, sif.ovr} !== '0)
      begin errors++; $display("FAIL %s: got waddr=%0d raddr=%0d seq=%0b done=%0b full=%0b ovr=%0b expected all 0", tag, sif.waddr, sif.raddr, sif.sequencing, sif.fir_done, sif.full, sif.ovr); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_zero("reset_state");
    checks++;
    if ({bif.waddr, bif.raddr, bif.sequencing, bif.fir_done, bif.full, bif.ovr} !== '0)
      begin errors++; $display("FAIL reset_big: got nonzero expected 0"); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 7; i++) begin
      strobe_idle();
      checks++;
      if (sif.sequencing !== 1'b0) begin errors++; $display("FAIL early_seq[%0d]: got 1 expected 0", i); end
    end
    checks++;
    if (sif.full !== 1'b0) begin errors++; $display("FAIL full_pre: got %0b expected 0", sif.full); end
    strobe_idle();
    run_window(-1, -1, 0);
    checks++;
    if (sif.full !== 1'b1) begin errors++; $display("FAIL full_post: got %0b expected 1", sif.full); end
  endtask

  task automatic test_wrap();
    while (mw != 2) begin strobe_idle(); run_window(-1, -1, 0); end
    strobe_idle();
    run_window(-1, -1, 0);
  endtask

  task automatic test_busy();
    strobe_idle();
    run_window(2, -1, 0);
    run_window(-1, -1, 1);
  endtask

  task automatic test_overrun();
    strobe_idle();
    run_window(1, 4, 0);
    run_window(-1, -1, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (sif.sequencing !== 1'b0 || sif.ovr !== 1'b1)
        begin errors++; $display("FAIL ovr_hold[%0d]: got seq=%0b ovr=%0b expected seq=0 ovr=1", i, sif.sequencing, sif.ovr); end
    end
  endtask

  task automatic test_reset_mid_seq();
    strobe_idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_seq");
    q.delete();
    mw = 0;
    mfill = 0;
    mpend = 1'b0;
    movr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("post_reset_idle");
    end
    for (int i = 0; i < 7; i++) strobe_idle();
    checks++;
    if (sif.sequencing !== 1'b0) begin errors++; $display("FAIL refill_seq: got 1 expected 0"); end
    strobe_idle();
    run_window(-1, -1, 0);
  endtask

  task automatic test_default_params();
    int n, first, last;
    bit early;
    early = 1'b0;
    for (int i = 0; i < 1021; i++) begin
      bif.wrt_smpl = 1'b1;
      @(negedge clk);
      bif.wrt_smpl = 1'b0;
      if (i < 1020 && bif.sequencing !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL big_early: got seq before 1021st strobe expected none"); end
    n = 0;
    first = int'(bif.raddr);
    last = -1;
    while (bif.sequencing === 1'b1 && n < 1100) begin
      last = int'(bif.raddr);
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 1021) begin errors++; $display("FAIL big_len: got %0d expected 1021", n); end
    checks++;
    if (first !== 0) begin errors++; $display("FAIL big_first: got %0d expected 0", first); end
    checks++;
    if (last !== 1020) begin errors++; $display("FAIL big_last: got %0d expected 1020", last); end
    checks++;
    if (bif.fir_done !== 1'b1) begin errors++; $display("FAIL big_done: got %0b expected 1", bif.fir_done); end
    checks++;
    if (bif.full !== 1'b1) begin errors++; $display("FAIL big_full: got %0b expected 1", bif.full); end
  endtask

  initial begin
    sif.wrt_smpl = 1'b0;
    bif.wrt_smpl = 1'b0;
    test_reset();
    test_fill();
    test_wrap();
    test_busy();
    test_overrun();
    test_reset_mid_seq();
    test_default_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
